// File: rtl/lab3_mem_cache_pkg.sv
// Shared types for the parametrised write-back cache: FSM states, memory message
// layouts and type codes, and the byte-enable decoder.
package lab3_mem_cache_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_TC, ST_WI, ST_RD, ST_WR, ST_EP, ST_EW, ST_RP, ST_RW, ST_W
  } state_e;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  // len=0 means a full word; shorter accesses shift by the byte offset
  function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
    case (len)
      2'd0:    byte_en = 4'b1111;
      2'd1:    byte_en = 4'b0001 << off;
      2'd2:    byte_en = 4'b0011 << off;
      2'd3:    byte_en = 4'b0111 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lab3_mem_cache_wb_param_dpath.sv
// Cache datapath: request latch, tag/data arrays, valid/dirty bits, write
// replication with byte enables, memory request build and response mux.
module lab3_mem_cache_wb_param_dpath
  import lab3_mem_cache_pkg::*;
#(
  parameter int p_num_lines = 16,
  parameter int p_num_banks = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req_en,
  input  mem_req_4B_t   i_req_msg,
  input  logic          i_init_en,
  input  logic          i_read_en,
  input  logic          i_write_en,
  input  logic          i_refill_en,
  input  logic          i_evict_sel,
  input  logic [127:0]  i_refill_data,
  output logic          o_hit,
  output logic          o_victim_dirty,
  output logic [2:0]    o_req_type,
  output mem_req_16B_t  o_memreq_msg,
  output mem_resp_4B_t  o_resp_msg
);

  localparam int B = $clog2(p_num_banks);
  localparam int I = $clog2(p_num_lines);
  localparam int T = 28 - B - I;

  mem_req_4B_t r_req;
  logic [31:0] r_rdata;
  logic [T-1:0] r_tags [p_num_lines];
  logic [127:0] r_data [p_num_lines];
  logic [p_num_lines-1:0] r_valid;
  logic [p_num_lines-1:0] r_dirty;

  logic [I-1:0]   w_idx;
  logic [T-1:0]   w_tag;
  logic [1:0]     w_word;
  logic [3:0]     w_be4;
  logic [15:0]    w_wben;
  logic [127:0]   w_wdata;

  assign w_idx   = r_req.addr[4+B +: I];
  assign w_tag   = r_req.addr[31 -: T];
  assign w_word  = r_req.addr[3:2];
  assign w_wdata = {4{r_req.data}};

  // Word-lane byte enables placed at the addressed word of the line
  always_comb begin
    w_be4  = byte_en(r_req.len, r_req.addr[1:0]);
    w_wben = {12'd0, w_be4} << {w_word, 2'b00};
  end

  // Request latch and read-word capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req   <= '0;
      r_rdata <= 32'd0;
    end else begin
      if (i_req_en)  r_req   <= i_req_msg;
      if (i_read_en) r_rdata <= r_data[w_idx][32*w_word +: 32];
    end
  end

  // Tag and data arrays are deliberately not reset
  always_ff @(posedge clk) begin
    if (i_refill_en) begin
      r_tags[w_idx] <= w_tag;
      r_data[w_idx] <= i_refill_data;
    end else if (i_init_en || i_write_en) begin
      if (i_init_en) r_tags[w_idx] <= w_tag;
      for (int b = 0; b < 16; b++) begin
        if (w_wben[b]) r_data[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Line state bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_refill_en || i_init_en) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (i_write_en) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  assign o_hit          = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign o_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
  assign o_req_type     = r_req.type_;

  // Eviction rebuilds the victim address from the stored tag and the request's idx/bank
  always_comb begin
    o_memreq_msg        = '0;
    o_memreq_msg.len    = 4'd0;
    o_memreq_msg.opaque = 8'd0;
    if (i_evict_sel) begin
      o_memreq_msg.type_ = MEM_TYPE_WRITE;
      o_memreq_msg.addr  = {r_tags[w_idx], r_req.addr[4 +: B+I], 4'b0000};
      o_memreq_msg.data  = r_data[w_idx];
    end else begin
      o_memreq_msg.type_ = MEM_TYPE_READ;
      o_memreq_msg.addr  = {r_req.addr[31:4], 4'b0000};
      o_memreq_msg.data  = 128'd0;
    end
  end

  always_comb begin
    o_resp_msg        = '0;
    o_resp_msg.type_  = r_req.type_;
    o_resp_msg.opaque = r_req.opaque;
    o_resp_msg.test   = 2'd0;
    o_resp_msg.len    = 2'd0;
    if (r_req.type_ == MEM_TYPE_READ) o_resp_msg.data = r_rdata;
    else                              o_resp_msg.data = 32'd0;
  end

endmodule

// File: rtl/lab3_mem_cache_wb_param.sv
// Blocking direct-mapped write-back cache: control FSM with registered
// handshake outputs driving the datapath sub-module.
module lab3_mem_cache_wb_param
  import lab3_mem_cache_pkg::*;
#(
  parameter int p_num_lines = 16,
  parameter int p_num_banks = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          proc2cache_reqstream_val,
  output logic          proc2cache_reqstream_rdy,
  input  mem_req_4B_t   proc2cache_reqstream_msg,
  output logic          proc2cache_respstream_val,
  input  logic          proc2cache_respstream_rdy,
  output mem_resp_4B_t  proc2cache_respstream_msg,
  output logic          cache2mem_reqstream_val,
  input  logic          cache2mem_reqstream_rdy,
  output mem_req_16B_t  cache2mem_reqstream_msg,
  input  logic          cache2mem_respstream_val,
  output logic          cache2mem_respstream_rdy,
  input  mem_resp_16B_t cache2mem_respstream_msg
);

  state_e r_state;
  logic r_req_rdy, r_resp_val, r_mreq_val, r_mresp_rdy;
  logic w_req_go, w_refill, w_hit, w_victim_dirty;
  logic [2:0] w_req_type;
  logic w_unused;

  assign w_req_go = r_req_rdy && proc2cache_reqstream_val;
  assign w_refill = (r_state == ST_RW) && r_mresp_rdy && cache2mem_respstream_val;
  assign w_unused = ^{cache2mem_respstream_msg.type_, cache2mem_respstream_msg.opaque,
                      cache2mem_respstream_msg.test, cache2mem_respstream_msg.len};

  // Control FSM; each transition also sets the handshake outputs of the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req_rdy   <= 1'b0;
      r_resp_val  <= 1'b0;
      r_mreq_val  <= 1'b0;
      r_mresp_rdy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_go) begin
            r_req_rdy <= 1'b0;
            r_state   <= ST_TC;
          end else begin
            r_req_rdy <= 1'b1;
          end
        end
        ST_TC: begin
          if (w_req_type == MEM_TYPE_INIT) r_state <= ST_WI;
          else if (w_hit) r_state <= (w_req_type == MEM_TYPE_READ) ? ST_RD : ST_WR;
          else begin
            r_mreq_val <= 1'b1;
            r_state    <= w_victim_dirty ? ST_EP : ST_RP;
          end
        end
        ST_WI, ST_RD, ST_WR: begin
          r_resp_val <= 1'b1;
          r_state    <= ST_W;
        end
        ST_EP: begin
          if (cache2mem_reqstream_rdy) begin
            r_mreq_val  <= 1'b0;
            r_mresp_rdy <= 1'b1;
            r_state     <= ST_EW;
          end
        end
        ST_EW: begin
          if (cache2mem_respstream_val) begin
            r_mresp_rdy <= 1'b0;
            r_mreq_val  <= 1'b1;
            r_state     <= ST_RP;
          end
        end
        ST_RP: begin
          if (cache2mem_reqstream_rdy) begin
            r_mreq_val  <= 1'b0;
            r_mresp_rdy <= 1'b1;
            r_state     <= ST_RW;
          end
        end
        ST_RW: begin
          if (w_refill) begin
            r_mresp_rdy <= 1'b0;
            r_state     <= ST_TC;
          end
        end
        ST_W: begin
          if (proc2cache_respstream_rdy) begin
            r_resp_val <= 1'b0;
            r_req_rdy  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_rdy   <= 1'b0;
          r_resp_val  <= 1'b0;
          r_mreq_val  <= 1'b0;
          r_mresp_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign proc2cache_reqstream_rdy  = r_req_rdy;
  assign proc2cache_respstream_val = r_resp_val;
  assign cache2mem_reqstream_val   = r_mreq_val;
  assign cache2mem_respstream_rdy  = r_mresp_rdy;

  lab3_mem_cache_wb_param_dpath #(
    .p_num_lines(p_num_lines),
    .p_num_banks(p_num_banks)
  ) u_dpath (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req_en       (w_req_go),
    .i_req_msg      (proc2cache_reqstream_msg),
    .i_init_en      (r_state == ST_WI),
    .i_read_en      (r_state == ST_RD),
    .i_write_en     (r_state == ST_WR),
    .i_refill_en    (w_refill),
    .i_evict_sel    (r_state == ST_EP),
    .i_refill_data  (cache2mem_respstream_msg.data),
    .o_hit          (w_hit),
    .o_victim_dirty (w_victim_dirty),
    .o_req_type     (w_req_type),
    .o_memreq_msg   (cache2mem_reqstream_msg),
    .o_resp_msg     (proc2cache_respstream_msg)
  );

endmodule

// File: tb/tb_lab3_mem_cache_wb_param.sv
// Scoreboard bench: two cache configurations share stimulus through a select,
// a behavioural memory answers line requests, monitors pop expected traffic.
module tb_lab3_mem_cache_wb_param;
  import lab3_mem_cache_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic req_val = 1'b0;
  mem_req_4B_t req_msg = '0;
  logic resp_rdy = 1'b1;
  logic mreq_rdy = 1'b1;
  logic mresp_val = 1'b0;
  mem_resp_16B_t mresp_msg = '0;

  logic a_req_rdy, a_resp_val, a_mreq_val, a_mresp_rdy;
  logic b_req_rdy, b_resp_val, b_mreq_val, b_mresp_rdy;
  mem_resp_4B_t a_resp_msg, b_resp_msg;
  mem_req_16B_t a_mreq_msg, b_mreq_msg;

  logic req_rdy, resp_val, mreq_val, mresp_rdy;
  mem_resp_4B_t resp_msg;
  mem_req_16B_t mreq_msg;
  assign req_rdy   = sel ? b_req_rdy   : a_req_rdy;
  assign resp_val  = sel ? b_resp_val  : a_resp_val;
  assign resp_msg  = sel ? b_resp_msg  : a_resp_msg;
  assign mreq_val  = sel ? b_mreq_val  : a_mreq_val;
  assign mreq_msg  = sel ? b_mreq_msg  : a_mreq_msg;
  assign mresp_rdy = sel ? b_mresp_rdy : a_mresp_rdy;

  lab3_mem_cache_wb_param #(.p_num_lines(16), .p_num_banks(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .proc2cache_reqstream_val(req_val && !sel), .proc2cache_reqstream_rdy(a_req_rdy),
    .proc2cache_reqstream_msg(req_msg),
    .proc2cache_respstream_val(a_resp_val), .proc2cache_respstream_rdy(resp_rdy),
    .proc2cache_respstream_msg(a_resp_msg),
    .cache2mem_reqstream_val(a_mreq_val), .cache2mem_reqstream_rdy(mreq_rdy),
    .cache2mem_reqstream_msg(a_mreq_msg),
    .cache2mem_respstream_val(mresp_val && !sel), .cache2mem_respstream_rdy(a_mresp_rdy),
    .cache2mem_respstream_msg(mresp_msg)
  );

  lab3_mem_cache_wb_param #(.p_num_lines(64), .p_num_banks(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .proc2cache_reqstream_val(req_val && sel), .proc2cache_reqstream_rdy(b_req_rdy),
    .proc2cache_reqstream_msg(req_msg),
    .proc2cache_respstream_val(b_resp_val), .proc2cache_respstream_rdy(resp_rdy),
    .proc2cache_respstream_msg(b_resp_msg),
    .cache2mem_reqstream_val(b_mreq_val), .cache2mem_reqstream_rdy(mreq_rdy),
    .cache2mem_reqstream_msg(b_mreq_msg),
    .cache2mem_respstream_val(mresp_val && sel), .cache2mem_respstream_rdy(b_mresp_rdy),
    .cache2mem_respstream_msg(mresp_msg)
  );

  mem_resp_4B_t exp_resp_q[$];
  mem_req_16B_t exp_mreq_q[$];
  logic [127:0] mem [logic [31:0]];
  int n_checks = 0;
  int n_pass = 0;
  int mem_lat = 0;
  int epoch = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    $display("FAIL %s: got an unexpected transfer, required none", name);
  endtask

  task automatic exp_mreq(input logic [2:0] t, input logic [31:0] addr, input logic [127:0] data);
    mem_req_16B_t e;
    e = '0;
    e.type_ = t;
    e.addr = addr;
    e.data = data;
    exp_mreq_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_data);
    mem_resp_4B_t e;
    e = '0;
    e.type_ = t;
    e.opaque = op;
    e.data = exp_data;
    exp_resp_q.push_back(e);
    req_msg.type_ = t;
    req_msg.opaque = op;
    req_msg.addr = addr;
    req_msg.len = 2'd0;
    req_msg.data = data;
    req_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_rdy) break;
    end
    check("req_accept", 128'(req_rdy), 128'd1);
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_resp_q.size() == 0 && exp_mreq_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 128'(exp_resp_q.size() + exp_mreq_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // Processor response monitor
  always @(negedge clk) begin
    if (reset_n && resp_val && resp_rdy) begin
      if (exp_resp_q.size() == 0) fail_evt("proc_resp");
      else check("proc_resp", 128'(resp_msg), 128'(exp_resp_q.pop_front()));
    end
  end

  // Memory model: checks each line request, then answers after mem_lat cycles
  initial begin : memory
    mem_req_16B_t m;
    mem_req_16B_t e;
    mem_resp_16B_t r;
    int ep;
    logic got;
    forever begin
      @(negedge clk);
      if (reset_n && mreq_val && mreq_rdy) begin
        m = mreq_msg;
        ep = epoch;
        if (exp_mreq_q.size() == 0) fail_evt("mem_req");
        else begin
          e = exp_mreq_q.pop_front();
          check("mem_req", 128'({m.type_, m.addr}), 128'({e.type_, e.addr}));
          if (e.type_ == MEM_TYPE_WRITE) check("mem_req_data", m.data, e.data);
        end
        r = '0;
        r.type_ = m.type_;
        r.opaque = m.opaque;
        if (m.type_ == MEM_TYPE_WRITE) mem[m.addr] = m.data;
        else r.data = mem.exists(m.addr) ? mem[m.addr] : 128'd0;
        @(posedge clk);
        for (int k = 0; k < mem_lat; k++) @(posedge clk);
        #1;
        if (ep == epoch) begin
          mresp_msg = r;
          mresp_val = 1'b1;
          got = 1'b0;
          for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ep != epoch) break;
            if (mresp_rdy) begin
              got = 1'b1;
              break;
            end
          end
          if (ep == epoch) check("mem_resp_accept", 128'(got), 128'd1);
          @(posedge clk);
          #1;
          mresp_val = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int lat;
    mem[32'h2000] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[32'h1100] = {32'h4444, 32'h3333, 32'h2222, 32'h55aa55aa};
    mem[32'h3000] = {32'h0, 32'h33330002, 32'h0, 32'h0};
    mem[32'h1230] = {32'ha3, 32'ha2, 32'ha1, 32'ha0};
    mem[32'h2230] = {32'hb3, 32'hb2, 32'hb1, 32'hb0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({req_rdy, resp_val, mreq_val, mresp_rdy}), 128'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Init then read hit, three-cycle latency, no memory traffic
    send(MEM_TYPE_INIT, 8'h01, 32'h1000, 32'hdeadbeef, 32'd0);
    wait_drain();
    send(MEM_TYPE_READ, 8'h02, 32'h1000, 32'd0, 32'hdeadbeef);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (resp_val) break;
    end
    check("hit_latency", 128'(lat), 128'd3);
    wait_drain();

    // Clean read miss
    exp_mreq(MEM_TYPE_READ, 32'h2000, 128'd0);
    send(MEM_TYPE_READ, 8'h03, 32'h2004, 32'd0, 32'h00000002);
    wait_drain();

    // Write hit, then a conflicting read evicts the dirty line
    send(MEM_TYPE_INIT, 8'h04, 32'h1000, 32'hdeadbeef, 32'd0);
    wait_drain();
    send(MEM_TYPE_WRITE, 8'h05, 32'h1008, 32'hcafe0000, 32'd0);
    wait_drain();
    exp_mreq(MEM_TYPE_WRITE, 32'h1000, {32'd4, 32'hcafe0000, 32'd2, 32'hdeadbeef});
    exp_mreq(MEM_TYPE_READ, 32'h1100, 128'd0);
    send(MEM_TYPE_READ, 8'h06, 32'h1100, 32'd0, 32'h55aa55aa);
    wait_drain();

    // Processor response back-pressure
    resp_rdy = 1'b0;
    send(MEM_TYPE_READ, 8'h07, 32'h1104, 32'd0, 32'h00002222);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_val) break;
    end
    for (int k = 0; k < 5; k++) begin
      check("resp_hold", 128'({resp_val, req_rdy, resp_msg.data}), 128'({1'b1, 1'b0, 32'h00002222}));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    wait_drain();

    // Memory request back-pressure
    mreq_rdy = 1'b0;
    exp_mreq(MEM_TYPE_READ, 32'h3000, 128'd0);
    send(MEM_TYPE_READ, 8'h08, 32'h3008, 32'd0, 32'h33330002);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mreq_val) break;
    end
    for (int k = 0; k < 5; k++) begin
      check("memreq_hold", 128'({mreq_val, mreq_msg.type_, mreq_msg.addr}),
            128'({1'b1, MEM_TYPE_READ, 32'h3000}));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mreq_rdy = 1'b1;
    wait_drain();

    // Reset while waiting for a refill clears the valid bits
    send(MEM_TYPE_INIT, 8'h09, 32'h1000, 32'h11111111, 32'd0);
    wait_drain();
    mem_lat = 20;
    exp_mreq(MEM_TYPE_READ, 32'h2040, 128'd0);
    send(MEM_TYPE_READ, 8'h0a, 32'h2040, 32'd0, 32'd0);
    for (int i = 0; i < 50; i++) begin
      if (exp_mreq_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    epoch++;
    exp_resp_q.delete();
    @(negedge clk);
    check("midmiss_reset_outputs", 128'({req_rdy, resp_val, mreq_val, mresp_rdy}), 128'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_lat = 0;
    exp_mreq(MEM_TYPE_READ, 32'h1000, 128'd0);
    send(MEM_TYPE_READ, 8'h0b, 32'h1000, 32'd0, 32'hdeadbeef);
    wait_drain();

    // Four banks, 64 lines: bank bits kept out of the tag but restored on eviction
    sel = 1'b1;
    @(posedge clk);
    #1;
    exp_mreq(MEM_TYPE_READ, 32'h1230, 128'd0);
    send(MEM_TYPE_READ, 8'h0c, 32'h1234, 32'd0, 32'h000000a1);
    wait_drain();
    send(MEM_TYPE_WRITE, 8'h0d, 32'h1238, 32'hbeef0002, 32'd0);
    wait_drain();
    exp_mreq(MEM_TYPE_WRITE, 32'h1230, {32'ha3, 32'hbeef0002, 32'ha1, 32'ha0});
    exp_mreq(MEM_TYPE_READ, 32'h2230, 128'd0);
    send(MEM_TYPE_READ, 8'h0e, 32'h2234, 32'd0, 32'h000000b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
